// File: rtl/cov_pkg.sv
// Shared types and width/index helpers for the streaming covariance unit.
package cov_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ACCUM = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } cov_state_t;

  function automatic int unsigned sum_w(input int unsigned ds, input int unsigned l2);
    return ds + l2;
  endfunction

  function automatic int unsigned prod_sum_w(input int unsigned ds, input int unsigned l2);
    return 2 * ds + l2;
  endfunction

  function automatic int unsigned acc_w(input int unsigned ds, input int unsigned l2);
    return 2 * ds + 2 * l2 + 1;
  endfunction

  // First linear upper-triangle index of row r.
  function automatic int unsigned row_base(input int unsigned r, input int unsigned dim);
    return (r * (2 * dim - r + 1)) / 2;
  endfunction

  function automatic int unsigned pair_row(input int unsigned p, input int unsigned dim);
    int unsigned base;
    int unsigned row;
    base = 0;
    row  = 0;
    for (int unsigned r = 0; r < dim; r++) begin
      if (p >= base + (dim - r)) row = r + 1;
      base = base + (dim - r);
    end
    return row;
  endfunction

  function automatic int unsigned pair_col(input int unsigned p, input int unsigned dim);
    int unsigned r;
    r = pair_row(p, dim);
    return r + (p - row_base(r, dim));
  endfunction

  // Linear index of upper-triangle entry (i,j), requires j >= i.
  function automatic int unsigned pair_index(input int unsigned i, input int unsigned j,
                                             input int unsigned dim);
    return row_base(i, dim) + (j - i);
  endfunction

endpackage

// File: rtl/cov_entry_calc.sv
// Finalises one covariance entry from its sums; COV_SATURATE_EN selects clamping instead of wrap.
module cov_entry_calc
  import cov_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned LOG2_SAMPLES = 4,
  parameter int unsigned OUT_WIDTH    = 32
) (
  input  logic signed [prod_sum_w(DATA_SIZE, LOG2_SAMPLES)-1:0] s_rc_i,
  input  logic signed [sum_w(DATA_SIZE, LOG2_SAMPLES)-1:0]      s_r_i,
  input  logic signed [sum_w(DATA_SIZE, LOG2_SAMPLES)-1:0]      s_c_i,
  output logic signed [OUT_WIDTH-1:0]                           cov_c_o
);

  localparam int unsigned ACW = acc_w(DATA_SIZE, LOG2_SAMPLES);

  logic signed [ACW-1:0] rc_ext;
  logic signed [ACW-1:0] lin_prod;
  logic signed [ACW-1:0] diff;
  logic signed [ACW-1:0] cov_full;

  // N*S_rc - S_r*S_c is exact in ACW; the arithmetic shift floors.
  always_comb begin
    rc_ext   = ACW'(s_rc_i) <<< LOG2_SAMPLES;
    lin_prod = ACW'(s_r_i) * ACW'(s_c_i);
    diff     = rc_ext - lin_prod;
    cov_full = diff >>> (2 * LOG2_SAMPLES);
  end

`ifdef COV_SATURATE_EN
  localparam int unsigned CW = ((ACW > OUT_WIDTH) ? ACW : OUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic signed [CW-1:0] cov_wide;

  always_comb begin
    cov_wide = CW'(cov_full);
    if (cov_wide > SAT_MAX)      cov_c_o = OUT_WIDTH'(SAT_MAX);
    else if (cov_wide < SAT_MIN) cov_c_o = OUT_WIDTH'(SAT_MIN);
    else                         cov_c_o = OUT_WIDTH'(cov_wide);
  end
`else
  assign cov_c_o = OUT_WIDTH'(cov_full);
`endif

endmodule

// File: rtl/cov_stream_unit.sv
// Streaming population-covariance unit: one time-shared MAC over the upper triangle,
// mirrored row-major emission over valid/ready. Optional clamping via COV_SATURATE_EN.
module cov_stream_unit
  import cov_pkg::*;
#(
  parameter int unsigned DIM          = 4,
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned LOG2_SAMPLES = 4,
  parameter int unsigned OUT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [DATA_SIZE-1:0]   sample_data [DIM],
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic [$clog2(DIM*DIM)-1:0]    out_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NPAIR = DIM * (DIM + 1) / 2;
  localparam int unsigned NENT  = DIM * DIM;
  localparam int unsigned AW    = $clog2(NENT);
  localparam int unsigned IW    = $clog2(DIM);
  localparam int unsigned PW    = $clog2(NPAIR);
  localparam int unsigned SW    = sum_w(DATA_SIZE, LOG2_SAMPLES);
  localparam int unsigned PSW   = prod_sum_w(DATA_SIZE, LOG2_SAMPLES);

  cov_state_t                  state_q, state_d;
  logic signed [DATA_SIZE-1:0] x_q [DIM];
  logic signed [DATA_SIZE-1:0] x_d [DIM];
  logic signed [PSW-1:0]       s_pair_q [NPAIR];
  logic signed [PSW-1:0]       s_pair_d [NPAIR];
  logic signed [SW-1:0]        s_lin_q [DIM];
  logic signed [SW-1:0]        s_lin_d [DIM];
  logic [PW-1:0]               pair_q, pair_d;
  logic [LOG2_SAMPLES-1:0]     smp_q, smp_d;
  logic [IW-1:0]               row_q, row_d, col_q, col_d;
  logic                        sready_q, sready_d;
  logic signed [OUT_WIDTH-1:0] odata_q, odata_d;
  logic [AW-1:0]               oaddr_q, oaddr_d;
  logic                        ovalid_q, ovalid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [IW-1:0]               acc_i, acc_j;
  logic signed [2*DATA_SIZE-1:0] prod;
  logic                        last_ent, adv_idx;
  logic [IW-1:0]               em_r, em_c, lo, hi;
  logic signed [PSW-1:0]       s_rc_sel;
  logic signed [OUT_WIDTH-1:0] cov_c;

  // MAC operands for the current upper-triangle pair.
  always_comb begin
    acc_i = IW'(pair_row(32'(pair_q), DIM));
    acc_j = IW'(pair_col(32'(pair_q), DIM));
    prod  = x_q[acc_i] * x_q[acc_j];
  end

  // Entry to be loaded into the output register next; lower-triangle reads mirror the upper store.
  always_comb begin
    last_ent = (oaddr_q == AW'(NENT - 1));
    adv_idx  = ovalid_q & out_ready & ~last_ent;
    em_r     = row_q;
    em_c     = col_q;
    if (adv_idx) begin
      if (col_q == IW'(DIM - 1)) begin
        em_c = '0;
        em_r = row_q + 1'b1;
      end else begin
        em_c = col_q + 1'b1;
      end
    end
    lo       = (em_r < em_c) ? em_r : em_c;
    hi       = (em_r < em_c) ? em_c : em_r;
    s_rc_sel = s_pair_q[PW'(pair_index(32'(lo), 32'(hi), DIM))];
  end

  cov_entry_calc #(
    .DATA_SIZE    (DATA_SIZE),
    .LOG2_SAMPLES (LOG2_SAMPLES),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_calc (
    .s_rc_i  (s_rc_sel),
    .s_r_i   (s_lin_q[em_r]),
    .s_c_i   (s_lin_q[em_c]),
    .cov_c_o (cov_c)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    s_pair_d = s_pair_q;
    s_lin_d  = s_lin_q;
    pair_d   = pair_q;
    smp_d    = smp_q;
    row_d    = row_q;
    col_d    = col_q;
    odata_d  = odata_q;
    oaddr_d  = oaddr_q;
    ovalid_d = ovalid_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < NPAIR; k++) s_pair_d[k] = '0;
          for (int unsigned k = 0; k < DIM; k++)   s_lin_d[k]  = '0;
          pair_d  = '0;
          smp_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sample_valid && sready_q) begin
          x_d     = sample_data;
          pair_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        s_pair_d[pair_q] = s_pair_q[pair_q] + PSW'(prod);
        if (acc_i == acc_j) s_lin_d[acc_i] = s_lin_q[acc_i] + SW'(x_q[acc_i]);
        if (pair_q == PW'(NPAIR - 1)) begin
          pair_d = '0;
          if (&smp_q) begin
            row_d   = '0;
            col_d   = '0;
            oaddr_d = '0;
            state_d = EMIT;
          end else begin
            smp_d   = smp_q + 1'b1;
            state_d = LOAD;
          end
        end else begin
          pair_d = pair_q + 1'b1;
        end
      end
      EMIT: begin
        if (!ovalid_q) begin
          ovalid_d = 1'b1;
          odata_d  = cov_c;
        end else if (out_ready) begin
          if (last_ent) begin
            ovalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            row_d   = em_r;
            col_d   = em_c;
            oaddr_d = oaddr_q + 1'b1;
            odata_d = cov_c;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sready_d = (state_d == LOAD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      for (int unsigned k = 0; k < DIM; k++) begin
        x_q[k]     <= '0;
        s_lin_q[k] <= '0;
      end
      for (int unsigned k = 0; k < NPAIR; k++) s_pair_q[k] <= '0;
      pair_q   <= '0;
      smp_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      sready_q <= 1'b0;
      odata_q  <= '0;
      oaddr_q  <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      s_pair_q <= s_pair_d;
      s_lin_q  <= s_lin_d;
      pair_q   <= pair_d;
      smp_q    <= smp_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sready_q <= sready_d;
      odata_q  <= odata_d;
      oaddr_q  <= oaddr_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sample_ready = sready_q;
  assign out_data     = odata_q;
  assign out_addr     = oaddr_q;
  assign out_valid    = ovalid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cov_stream_unit.sv
// Directed bench: default 4x4 instance plus a 2x2, N=2, 8-bit-output instance.
module tb_cov_stream_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default-parameter instance
  logic              d_start, d_svalid, d_sready, d_ovalid, d_oready, d_busy, d_done;
  logic signed [7:0] d_sdata [4];
  logic [31:0]       d_odata;
  logic [3:0]        d_oaddr;

  // DIM=2, LOG2_SAMPLES=1, OUT_WIDTH=8 instance
  logic              s_start, s_svalid, s_sready, s_ovalid, s_oready, s_busy, s_done;
  logic signed [7:0] s_sdata [2];
  logic [7:0]        s_odata;
  logic [1:0]        s_oaddr;

  cov_stream_unit u_dut (
    .clk          (clk),
    .rst          (rst_n),
    .start        (d_start),
    .sample_data  (d_sdata),
    .sample_valid (d_svalid),
    .sample_ready (d_sready),
    .out_data     (d_odata),
    .out_addr     (d_oaddr),
    .out_valid    (d_ovalid),
    .out_ready    (d_oready),
    .busy         (d_busy),
    .done         (d_done)
  );

  cov_stream_unit #(
    .DIM          (2),
    .DATA_SIZE    (8),
    .LOG2_SAMPLES (1),
    .OUT_WIDTH    (8)
  ) u_dut_small (
    .clk          (clk),
    .rst          (rst_n),
    .start        (s_start),
    .sample_data  (s_sdata),
    .sample_valid (s_svalid),
    .sample_ready (s_sready),
    .out_data     (s_odata),
    .out_addr     (s_oaddr),
    .out_valid    (s_ovalid),
    .out_ready    (s_oready),
    .busy         (s_busy),
    .done         (s_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int d_smp [16][4];
  int d_exp [16];
  int s_exp [4];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_small(input int a0, input int a1, input int b0, input int b1,
                           input string tag);
    int t;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      while (!s_sready && t < 100) begin @(negedge clk); t++; end
      check_val($sformatf("%s_sready_wait%0d", tag, k), longint'(t < 100), 1);
      s_sdata[0] = 8'((k == 0) ? a0 : b0);
      s_sdata[1] = 8'((k == 0) ? a1 : b1);
      s_svalid   = 1'b1;
      @(negedge clk) s_svalid = 1'b0;
    end
    s_oready = 1'b1;
    for (int e = 0; e < 4; e++) begin
      t = 0;
      while (!s_ovalid && t < 100) begin @(negedge clk); t++; end
      check_val($sformatf("%s_valid_wait%0d", tag, e), longint'(t < 100), 1);
      check_val($sformatf("%s_addr%0d", tag, e), longint'(s_oaddr), e);
      check_val($sformatf("%s_data%0d", tag, e), longint'($signed(s_odata)), s_exp[e]);
      @(negedge clk);
    end
    check_val({tag, "_done_pulse"}, longint'(s_done), 1);
    @(negedge clk);
    check_val({tag, "_done_clear"}, longint'(s_done), 0);
    check_val({tag, "_idle"}, longint'(s_busy), 0);
  endtask

  // Samples offered with garbage held valid while not ready; only ready cycles may consume.
  task automatic feed_default(input int count, input bit poke, input string tag);
    int t;
    for (int k = 0; k < count; k++) begin
      t = 0;
      while (!d_sready && t < 200) begin
        for (int c = 0; c < 4; c++) d_sdata[c] = 8'sd77;
        d_svalid = 1'b1;
        @(negedge clk);
        t++;
      end
      check_val($sformatf("%s_sready_wait%0d", tag, k), longint'(t < 200), 1);
      for (int c = 0; c < 4; c++) d_sdata[c] = 8'(d_smp[k][c]);
      d_svalid = 1'b1;
      if (poke && k == 1) d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      if (k == 0) check_val({tag, "_sready_in_accum"}, longint'(d_sready), 0);
    end
    d_svalid = 1'b0;
  endtask

  task automatic run_default(input bit stall, input bit poke, input string tag);
    int t;
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0;
    feed_default(16, poke, tag);
    d_oready = 1'b1;
    for (int e = 0; e < 16; e++) begin
      t = 0;
      while (!d_ovalid && t < 300) begin @(negedge clk); t++; end
      check_val($sformatf("%s_valid_wait%0d", tag, e), longint'(t < 300), 1);
      check_val($sformatf("%s_addr%0d", tag, e), longint'(d_oaddr), e);
      check_val($sformatf("%s_data%0d", tag, e), longint'($signed(d_odata)), d_exp[e]);
      if (stall && e == 6) begin
        d_oready = 1'b0;
        if (poke) d_start = 1'b1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          d_start = 1'b0;
          check_val($sformatf("%s_hold_addr%0d", tag, s), longint'(d_oaddr), 6);
          check_val($sformatf("%s_hold_data%0d", tag, s), longint'($signed(d_odata)), d_exp[6]);
          check_val($sformatf("%s_hold_valid%0d", tag, s), longint'(d_ovalid), 1);
        end
        d_oready = 1'b1;
      end
      @(negedge clk);
    end
    check_val({tag, "_done_pulse"}, longint'(d_done), 1);
    check_val({tag, "_valid_low"}, longint'(d_ovalid), 0);
    @(negedge clk);
    check_val({tag, "_done_clear"}, longint'(d_done), 0);
    @(negedge clk);
    check_val({tag, "_no_restart"}, longint'(d_busy), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    d_start  = 1'b0;
    d_svalid = 1'b0;
    d_oready = 1'b0;
    s_start  = 1'b0;
    s_svalid = 1'b0;
    s_oready = 1'b0;
    for (int c = 0; c < 4; c++) d_sdata[c] = '0;
    for (int c = 0; c < 2; c++) s_sdata[c] = '0;

    repeat (3) @(negedge clk);
    check_val("rst_sready", longint'(d_sready), 0);
    check_val("rst_ovalid", longint'(d_ovalid), 0);
    check_val("rst_busy", longint'(d_busy), 0);
    check_val("rst_done", longint'(d_done), 0);
    check_val("rst_odata", longint'(d_odata), 0);
    check_val("rst_oaddr", longint'(d_oaddr), 0);
    check_val("rst_small_busy", longint'(s_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    s_exp = '{1, 2, 2, 4};
    run_small(1, 2, 3, 6, "basic");
    s_exp = '{1, -1, -1, 1};
    run_small(-1, 1, 1, -1, "signed");
`ifdef COV_SATURATE_EN
    s_exp = '{127, 0, 0, 0};
`else
    s_exp = '{-128, 0, 0, 0};
`endif
    run_small(-128, 0, 127, 0, "outrange");

    // x0 alternates +-20, x1 = +-10 by half, x2 = 30/10 by half, x3 = k
    for (int k = 0; k < 16; k++) begin
      d_smp[k][0] = (k % 2 == 0) ? 20 : -20;
      d_smp[k][1] = (k < 8) ? 10 : -10;
      d_smp[k][2] = (k < 8) ? 30 : 10;
      d_smp[k][3] = k;
    end
    d_exp = '{400, 0, 0, -10, 0, 100, 100, -40, 0, 100, 100, -40, -10, -40, -40, 21};
    run_default(1'b1, 1'b1, "stall");

    // Reset during ACCUM of the fourth sample, then a constant run
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0;
    feed_default(4, 1'b0, "abort");
    @(negedge clk);
    check_val("abort_busy_before", longint'(d_busy), 1);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", longint'(d_busy), 0);
    check_val("abort_sready", longint'(d_sready), 0);
    check_val("abort_ovalid", longint'(d_ovalid), 0);
    check_val("abort_done", longint'(d_done), 0);
    check_val("abort_odata", longint'(d_odata), 0);
    check_val("abort_oaddr", longint'(d_oaddr), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("abort_no_emit", longint'(d_ovalid), 0);
    check_val("abort_stays_idle", longint'(d_busy), 0);

    for (int k = 0; k < 16; k++)
      for (int c = 0; c < 4; c++) d_smp[k][c] = 5;
    for (int e = 0; e < 16; e++) d_exp[e] = 0;
    run_default(1'b0, 1'b0, "const");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
